// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encoding, defaults and sizing helper for the CNN front-end sequencer.
package cnn_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_FLUSH, S_WAIT_RES, S_HOLD} state_t;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam logic [3:0] CLASS_ERR = 4'hF;
  localparam int RES_W = 32;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter that holds at zero and flags it.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en && !o_zero) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/infer_frame_sequencer.sv
// infer_frame_sequencer: paces a pixel stream into the CNN pipeline, flushes it,
// waits for the class result with a timeout and holds it for a consumer.
module infer_frame_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int PIX_GAP   = 50,
  parameter int FLUSH_LEN = 100,
  parameter int TIMEOUT   = 500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  output logic                    s_ready,
  input  logic                    abort,
  output logic                    m_valid,
  output logic [7:0]              m_data,
  input  logic                    class_valid,
  input  logic [3:0]              class_out,
  input  logic signed [RES_W-1:0] class_value,
  output logic                    res_valid,
  output logic [3:0]              res_class,
  output logic signed [RES_W-1:0] res_value,
  output logic                    res_err,
  input  logic                    res_ready,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);
  localparam int CW = cw(IMG_W);
  localparam int RW = cw(IMG_H);
  localparam int GW = cw(PIX_GAP);
  localparam int FW = cw(FLUSH_LEN + 1);
  localparam int TW = cw(TIMEOUT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t                    r_state;
  logic [CW-1:0]             r_col;
  logic [RW-1:0]             r_row;
  logic                      r_last;
  logic                      r_got;
  logic                      r_m_valid;
  logic [7:0]                r_m_data;
  logic                      r_res_valid;
  logic [3:0]                r_res_class;
  logic signed [RES_W-1:0]   r_res_value;
  logic                      r_res_err;
  logic [15:0]               r_frame_cnt;
  logic                      w_accept, w_col_end, w_last, w_cap;
  logic                      w_gap_zero, w_flush_zero, w_to_zero;

  assign s_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_accept  = s_valid && s_ready;
  assign w_col_end = r_col == COL_MAX;
  assign w_last    = w_col_end && (r_row == ROW_MAX);
  assign w_cap     = class_valid && !r_got &&
                     (r_state inside {S_LOAD, S_GAP, S_FLUSH, S_WAIT_RES});

  // Gap loads one less than PIX_GAP so PIX_GAP idle cycles separate m_valid pulses.
  seq_down_counter #(.W(GW)) u_gap (
    .clk(clk), .rst_n(rst_n), .i_load(abort || w_accept),
    .i_val(abort ? '0 : GW'(PIX_GAP - 1)), .i_en(r_state == S_GAP), .o_zero(w_gap_zero)
  );
  seq_down_counter #(.W(FW)) u_flush (
    .clk(clk), .rst_n(rst_n), .i_load(abort || (r_state == S_GAP && w_gap_zero && r_last)),
    .i_val(abort ? '0 : FW'(FLUSH_LEN)), .i_en(r_state == S_FLUSH), .o_zero(w_flush_zero)
  );
  seq_down_counter #(.W(TW)) u_timeout (
    .clk(clk), .rst_n(rst_n), .i_load(abort || (r_state == S_FLUSH && w_flush_zero)),
    .i_val(abort ? '0 : TW'(TIMEOUT - 1)), .i_en(r_state == S_WAIT_RES), .o_zero(w_to_zero)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_last      <= 1'b0;
      r_got       <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_res_valid <= 1'b0;
      r_res_class <= '0;
      r_res_value <= '0;
      r_res_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_last      <= 1'b0;
      r_got       <= 1'b0;
      r_m_valid   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_m_valid <= 1'b0;
      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_data;
        r_last    <= w_last;
        r_col     <= w_col_end ? '0 : r_col + 1'b1;
        r_row     <= w_last ? '0 : w_col_end ? r_row + 1'b1 : r_row;
      end
      if (w_cap) begin
        r_got       <= 1'b1;
        r_res_class <= class_out;
        r_res_value <= class_value;
      end
      case (r_state)
        S_IDLE, S_LOAD: if (w_accept) r_state <= S_GAP;
        S_GAP:          if (w_gap_zero) r_state <= r_last ? S_FLUSH : S_LOAD;
        S_FLUSH:
          if (w_flush_zero) r_state <= S_WAIT_RES;
          else begin
            r_m_valid <= 1'b1;
            r_m_data  <= '0;
          end
        S_WAIT_RES:
          if (r_got || class_valid) begin
            r_state     <= S_HOLD;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b0;
          end else if (w_to_zero) begin
            r_state     <= S_HOLD;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_res_class <= CLASS_ERR;
            r_res_value <= '0;
          end
        S_HOLD:
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_got       <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        default: r_state <= S_IDLE;
      endcase
    end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign res_valid = r_res_valid;
  assign res_class = r_res_class;
  assign res_value = r_res_value;
  assign res_err   = r_res_err;
  assign busy      = r_state != S_IDLE;
  assign frame_cnt = r_frame_cnt;
endmodule
